// File: rtl/lfsr_rr_sched.sv
// One Fibonacci LFSR shared round-robin among NUM_REQ requesters; each grant gets a WIDTH-bit serial burst.
// Optional macro LFSR_SCHED_PARITY_EN appends a parity beat and exposes the Par_Beat port.
module lfsr_rr_sched #(
    parameter int unsigned      WIDTH   = 4,
    parameter logic [WIDTH-1:0] TAPS    = 4'b1100,
    parameter int unsigned      WARMUP  = 8,
    parameter int unsigned      NUM_REQ = 2
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [WIDTH-1:0]   Seed,
    input  logic               Seed_Load,
    input  logic [NUM_REQ-1:0] Req,
    output logic [NUM_REQ-1:0] Grant,
    output logic               OUT,
    output logic               Valid,
    output logic               Last,
    output logic               Busy
`ifdef LFSR_SCHED_PARITY_EN
    ,
    output logic               Par_Beat
`endif
);

`ifdef LFSR_SCHED_PARITY_EN
    localparam int unsigned NBEATS = WIDTH + 1;
`else
    localparam int unsigned NBEATS = WIDTH;
`endif
    localparam int unsigned CMAX = (WARMUP > NBEATS) ? WARMUP : NBEATS;
    localparam int unsigned CW   = $clog2(CMAX + 1);
    localparam int unsigned PW   = $clog2(NUM_REQ);

    // LOAD: seed sample | WARMUP: discard shifts | IDLE: arbitrate | SERVE: burst out
    typedef enum logic [1:0] {S_LOAD, S_WARMUP, S_IDLE, S_SERVE} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   lfsr_q, lfsr_d, lfsr_shift;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [PW-1:0]      rr_ptr_q, rr_ptr_d, gidx_q, gidx_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic               out_q, out_d, valid_q, valid_d, last_q, last_d;
`ifdef LFSR_SCHED_PARITY_EN
    logic               par_q, par_d, pbeat_q, pbeat_d;
`endif
    logic               reseed;
    logic [PW-1:0]      pick_idx;
    logic               pick_hit;
    logic [PW:0]        sum;

    assign lfsr_shift = {lfsr_q[WIDTH-2:0], ^(lfsr_q & TAPS)};
    assign reseed     = Seed_Load && (state_q != S_LOAD);

    // Descending scan so the smallest offset from rr_ptr wins.
    always_comb begin
        pick_idx = '0;
        pick_hit = 1'b0;
        sum      = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            sum = {1'b0, rr_ptr_q} + (PW+1)'(i);
            if (sum >= (PW+1)'(NUM_REQ)) sum = sum - (PW+1)'(NUM_REQ);
            if (Req[sum[PW-1:0]]) begin
                pick_idx = sum[PW-1:0];
                pick_hit = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q  <= S_LOAD;
            lfsr_q   <= WIDTH'(1);
            cnt_q    <= '0;
            rr_ptr_q <= '0;
            gidx_q   <= '0;
            grant_q  <= '0;
            out_q    <= 1'b0;
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
`ifdef LFSR_SCHED_PARITY_EN
            par_q    <= 1'b0;
            pbeat_q  <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            lfsr_q   <= lfsr_d;
            cnt_q    <= cnt_d;
            rr_ptr_q <= rr_ptr_d;
            gidx_q   <= gidx_d;
            grant_q  <= grant_d;
            out_q    <= out_d;
            valid_q  <= valid_d;
            last_q   <= last_d;
`ifdef LFSR_SCHED_PARITY_EN
            par_q    <= par_d;
            pbeat_q  <= pbeat_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        if (reseed) begin
            state_d = S_LOAD;
        end else begin
            case (state_q)
                S_LOAD:   state_d = S_WARMUP;
                S_WARMUP: if (cnt_q == CW'(WARMUP - 1)) state_d = S_IDLE;
                S_IDLE:   if (pick_hit) state_d = S_SERVE;
                S_SERVE:  if (cnt_q == CW'(NBEATS)) state_d = S_IDLE;
                default:  state_d = S_LOAD;
            endcase
        end
    end

    always_comb begin
        lfsr_d   = lfsr_q;
        cnt_d    = cnt_q;
        rr_ptr_d = rr_ptr_q;
        gidx_d   = gidx_q;
        grant_d  = grant_q;
        out_d    = out_q;
        valid_d  = valid_q;
        last_d   = last_q;
`ifdef LFSR_SCHED_PARITY_EN
        par_d    = par_q;
        pbeat_d  = pbeat_q;
`endif
        if (reseed) begin
            grant_d = '0;
            valid_d = 1'b0;
            last_d  = 1'b0;
            out_d   = 1'b0;
`ifdef LFSR_SCHED_PARITY_EN
            pbeat_d = 1'b0;
`endif
        end else begin
            case (state_q)
                S_LOAD: begin
                    lfsr_d = (Seed == '0) ? WIDTH'(1) : Seed;
                    cnt_d  = '0;
                end
                S_WARMUP: begin
                    lfsr_d = lfsr_shift;
                    cnt_d  = cnt_q + CW'(1);
                end
                S_IDLE: begin
                    if (pick_hit) begin
                        gidx_d  = pick_idx;
                        grant_d = NUM_REQ'(1) << pick_idx;
                        valid_d = 1'b1;
                        out_d   = lfsr_q[WIDTH-1];
                        lfsr_d  = lfsr_shift;
                        cnt_d   = CW'(1);
                        last_d  = (CW'(NBEATS) == CW'(1));
`ifdef LFSR_SCHED_PARITY_EN
                        par_d   = lfsr_q[WIDTH-1];
                        pbeat_d = 1'b0;
`endif
                    end
                end
                S_SERVE: begin
                    if (cnt_q == CW'(NBEATS)) begin
                        grant_d  = '0;
                        valid_d  = 1'b0;
                        last_d   = 1'b0;
                        out_d    = 1'b0;
                        rr_ptr_d = (gidx_q == PW'(NUM_REQ - 1)) ? '0 : gidx_q + PW'(1);
`ifdef LFSR_SCHED_PARITY_EN
                        pbeat_d  = 1'b0;
`endif
                    end else begin
                        cnt_d  = cnt_q + CW'(1);
                        last_d = ((cnt_q + CW'(1)) == CW'(NBEATS));
`ifdef LFSR_SCHED_PARITY_EN
                        if (cnt_q == CW'(WIDTH)) begin
                            out_d   = par_q;
                            pbeat_d = 1'b1;
                        end else begin
                            out_d  = lfsr_q[WIDTH-1];
                            lfsr_d = lfsr_shift;
                            par_d  = par_q ^ lfsr_q[WIDTH-1];
                        end
`else
                        out_d  = lfsr_q[WIDTH-1];
                        lfsr_d = lfsr_shift;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    assign Grant = grant_q;
    assign OUT   = out_q;
    assign Valid = valid_q;
    assign Last  = last_q;
    assign Busy  = (state_q != S_IDLE);
`ifdef LFSR_SCHED_PARITY_EN
    assign Par_Beat = pbeat_q;
`endif

endmodule

// File: tb/tb_lfsr_rr_sched.sv
// Scoreboard bench for lfsr_rr_sched: stimulus pushes expected bursts, a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_lfsr_rr_sched;
    localparam int W = 4;
    localparam int N = 2;
    localparam logic [W-1:0] TAPS = 4'b1100;
`ifdef LFSR_SCHED_PARITY_EN
    localparam int NB = W + 1;
`else
    localparam int NB = W;
`endif

    logic         CLK = 1'b0;
    logic         RST;
    logic [W-1:0] Seed;
    logic         Seed_Load;
    logic [N-1:0] Req;
    logic [N-1:0] Grant;
    logic         OUT, Valid, Last, Busy;
`ifdef LFSR_SCHED_PARITY_EN
    logic         Par_Beat;
`endif

    lfsr_rr_sched dut (
        .CLK(CLK), .RST(RST), .Seed(Seed), .Seed_Load(Seed_Load), .Req(Req),
        .Grant(Grant), .OUT(OUT), .Valid(Valid), .Last(Last), .Busy(Busy)
`ifdef LFSR_SCHED_PARITY_EN
        , .Par_Beat(Par_Beat)
`endif
    );

    always #500 CLK = ~CLK;

    typedef struct {
        logic [N-1:0]  grant;
        logic [NB-1:0] bits;     // bit index == beat number
        int            nbeats;
        bit            last_ok;
    } exp_t;

    exp_t         sbq[$];
    int           checks = 0;
    int           errors = 0;
    logic [W-1:0] m_lfsr;
    int           m_ptr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] step(input logic [W-1:0] v);
        return {v[W-2:0], ^(v & TAPS)};
    endfunction

    task automatic seed_model(input logic [W-1:0] s);
        m_lfsr = (s == 0) ? W'(1) : s;
        repeat (8) m_lfsr = step(m_lfsr);
    endtask

    function automatic int pick(input logic [N-1:0] r);
        for (int i = 0; i < N; i++) begin
            if (r[(m_ptr + i) % N]) return (m_ptr + i) % N;
        end
        return 0;
    endfunction

    task automatic check_warmup();
        for (int i = 0; i < 9; i++) begin
            #1 chk("busy_warm", Busy, 1);
            @(negedge CLK);
        end
        #1 chk("busy_idle", Busy, 0);
    endtask

    // mode 0: full burst, 1: Seed_Load on beat 2, 2: reset on beat 2
    task automatic do_burst(input logic [N-1:0] r, input bit use_c, input logic [N-1:0] cg,
                            input logic [W-1:0] cbits, input int mode);
        exp_t e;
        int   g;
        logic par;
        g = pick(r);
        e.grant = N'(1) << g;
        e.bits = '0;
        par = 1'b0;
        for (int b = 0; b < W; b++) begin
            e.bits[b] = m_lfsr[W-1];
            par ^= m_lfsr[W-1];
            m_lfsr = step(m_lfsr);
        end
        if (use_c) begin
            e.grant = cg;
            e.bits[W-1:0] = cbits;
            par = ^cbits;
        end
`ifdef LFSR_SCHED_PARITY_EN
        e.bits[W] = par;
`endif
        e.nbeats = NB;
        e.last_ok = 1'b1;
        if (mode != 0) begin
            e.nbeats = 2;
            e.last_ok = 1'b0;
        end else begin
            m_ptr = (g + 1) % N;
        end
        sbq.push_back(e);
        Req = r;
        if (mode == 0) begin
            for (int k = 0; k < NB; k++) begin
                @(negedge CLK);
                #1 Req = N'($urandom);
            end
            @(negedge CLK);
            #1 chk("busy_gap", Busy, 0);
            Req = '0;
        end else begin
            @(negedge CLK);
            #1 Req = N'($urandom);
            @(negedge CLK);
            if (mode == 1) begin
                Seed = W'($urandom);
                Seed_Load = 1'b1;
                @(negedge CLK);
                Seed_Load = 1'b0;
                Req = '0;
                #1 chk("trunc_valid", Valid, 0);
                chk("trunc_grant", Grant, 0);
                chk("trunc_last", Last, 0);
            end else begin
                #200 RST = 1'b0;
                #1 chk("rst_grant", Grant, 0);
                chk("rst_valid", Valid, 0);
                chk("rst_out", OUT, 0);
                chk("rst_last", Last, 0);
                chk("rst_busy", Busy, 1);
                Req = '0;
                @(negedge CLK);
                RST = 1'b1;
                m_ptr = 0;
            end
            seed_model(Seed);
            check_warmup();
        end
    endtask

    task automatic seed_collide(input logic [N-1:0] r, input logic [W-1:0] s);
        Req = r;
        Seed = s;
        Seed_Load = 1'b1;
        @(negedge CLK);
        Seed_Load = 1'b0;
        Req = '0;
        #1 chk("reload_valid", Valid, 0);
        chk("reload_grant", Grant, 0);
        seed_model(s);
        check_warmup();
    endtask

    // Monitor
    exp_t cur;
    bit   inb = 1'b0;
    int   beat = 0;
    always @(negedge CLK) begin
        if (Valid) begin
            if (!inb) begin
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_burst: Valid=1 Grant=%b with nothing expected at %0t", Grant, $time);
                end else begin
                    cur = sbq.pop_front();
                    inb = 1'b1;
                    beat = 0;
                end
            end
            if (inb) begin
                if (beat >= cur.nbeats) begin
                    chk("burst_overrun", beat, cur.nbeats - 1);
                end else begin
                    chk("beat_grant", Grant, cur.grant);
                    chk("beat_out", OUT, cur.bits[beat]);
                    chk("beat_last", Last, (cur.last_ok && beat == cur.nbeats - 1));
`ifdef LFSR_SCHED_PARITY_EN
                    chk("beat_par", Par_Beat, (beat == W));
`endif
                end
                beat++;
            end
        end else if (inb) begin
            chk("burst_len", beat, cur.nbeats);
            chk("idle_grant", Grant, 0);
            inb = 1'b0;
        end
        chk("grant_onehot", $onehot0(Grant), 1);
    end

    initial begin
        int           act;
        logic [N-1:0] r;
        RST = 1'b0;
        Seed = 4'b1001;
        Seed_Load = 1'b0;
        Req = '0;
        #1;
        chk("reset_grant", Grant, 0);
        chk("reset_out", OUT, 0);
        chk("reset_valid", Valid, 0);
        chk("reset_last", Last, 0);
        chk("reset_busy", Busy, 1);
        repeat (2) @(negedge CLK);
        RST = 1'b1;
        m_ptr = 0;
        seed_model(Seed);
        check_warmup();

        do_burst(2'b01, 1'b1, 2'b01, 4'b1111, 0);
        do_burst(2'b11, 1'b1, 2'b10, 4'b1000, 0);
        do_burst(2'b11, 1'b1, 2'b01, 4'b1100, 0);

        seed_collide(2'b00, 4'b0000);
        repeat (3) do_burst(N'($urandom_range(1, 3)), 1'b0, '0, '0, 0);

        do_burst(2'b10, 1'b0, '0, '0, 1);
        do_burst(2'b11, 1'b0, '0, '0, 0);
        seed_collide(2'b11, W'($urandom));
        do_burst(2'b01, 1'b0, '0, '0, 2);
        do_burst(2'b10, 1'b0, '0, '0, 0);

        for (int it = 0; it < 40; it++) begin
            act = $urandom_range(0, 9);
            r = N'($urandom_range(1, 3));
            if (act < 6) begin
                do_burst(r, 1'b0, '0, '0, 0);
            end else if (act == 6) begin
                Req = '0;
                repeat ($urandom_range(1, 3)) @(negedge CLK);
                #1 chk("idle_busy", Busy, 0);
            end else if (act == 7) begin
                do_burst(r, 1'b0, '0, '0, 1);
            end else if (act == 8) begin
                seed_collide(r, W'($urandom));
            end else begin
                do_burst(r, 1'b0, '0, '0, 2);
            end
        end

        Req = '0;
        repeat (3) @(negedge CLK);
        #1 chk("queue_drained", sbq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
